// File: rtl/softplus_vec_seq.sv
// Vector sequencer for a shared combinational softplus unit: reads each operand from a
// synchronous-read buffer, presents it to the softplus datapath, captures the result and
// streams it out on a valid/ready handshake, then pulses done.
module softplus_vec_seq #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [15:0]       sp_operand,
    input  logic [15:0]       sp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLd,
        StEv,
        StOut,
        StDone
    } state_e;

    localparam logic [ADDR_W:0]   DepthLen = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IdxOne   = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [15:0]       op_q, op_d;
    logic [15:0]       res_q, res_d;
    logic              last_elem;

    // Current element is the final one of the run.
    assign last_elem = ({1'b0, idx_q} == (len_q - LenOne));

    // State and datapath registers; op/res are only cleared by reset so sp_operand stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic; abort outranks every other transition outside IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        op_d    = op_q;
        res_d   = res_q;
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_d   = (len > DepthLen) ? DepthLen : len;
                        idx_d   = '0;
                        state_d = (len == '0) ? StDone : StRd;
                    end
                end
                StRd: state_d = StLd;
                StLd: begin
                    op_d    = rd_data;
                    state_d = StEv;
                end
                StEv: begin
                    // sp_operand has been stable a full cycle, so sp_result has settled.
                    res_d   = sp_result;
                    state_d = StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        if (last_elem) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + IdxOne;
                            state_d = StRd;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign rd_en      = (state_q == StRd);
    assign rd_addr    = idx_q;
    assign sp_operand = op_q;
    assign out_valid  = (state_q == StOut);
    assign out_data   = res_q;
    assign out_idx    = idx_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);

endmodule

// File: doc/softplus_vec_seq.md
Name: softplus_vec_seq

Overview:
- Sequencer that applies the shared combinational softplus datapath to a vector of 16-bit operands held in a synchronous-read buffer.
- Walks the buffer element by element, presents each operand to the softplus unit, and captures its result.
- Streams each result downstream on a valid/ready handshake, then pulses done.
- Sits between the VAE layer buffers and a single softplus instance, so one datapath instance serves a whole activation vector.

Parameters:
- DEPTH, 64, maximum vector length (buffer entries).
- ADDR_W, 6, buffer address width; DEPTH must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a vector run; sampled only in IDLE.
- len  input  ADDR_W+1  element count, 0..DEPTH; latched when start is accepted.
- abort  input  1  synchronous abandon of the current run.
- rd_en  output  1  buffer read strobe.
- rd_addr  output  ADDR_W  buffer read address.
- rd_data  input  16  buffer data, valid the cycle after rd_en.
- sp_operand  output  16  operand to the softplus unit; registered.
- sp_result  input  16  combinational softplus output for sp_operand.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  16  softplus result.
- out_idx  output  ADDR_W  element index of out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a completed run.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - state = IDLE; idx, len_reg, op_reg, res_reg = 0.
  - All outputs 0: rd_en, rd_addr, sp_operand, out_valid, out_data, out_idx, busy, done.
- Outputs are driven from registers:
  - sp_operand = op_reg; out_data = res_reg; out_idx = idx; rd_addr = idx.
- FSM states: IDLE, RD, LD, EV, OUT, DONE.
  - IDLE: on start=1, len_reg ← len and idx ← 0. Next state is DONE if len=0, otherwise RD.
  - RD: rd_en=1 for exactly this cycle → LD.
  - LD: op_reg ← rd_data → EV.
  - EV: sp_operand has been stable one full cycle; res_reg ← sp_result → OUT.
  - OUT: out_valid=1; out_data and out_idx held stable while out_valid=1 and out_ready=0 (unbounded stall allowed). On out_valid & out_ready:
    - if idx = len_reg−1 → DONE;
    - else idx ← idx+1 → RD.
  - DONE: done=1 for one cycle → IDLE.
- Timing:
  - start accepted at edge k: rd_en high in cycle k+1, first out_valid in cycle k+4.
  - With out_ready held high: 4 cycles per element, and done is high in cycle k+4·len+1.
  - len=0: done is high in cycle k+1; no rd_en and no out_valid.
- start while busy is ignored; len is not re-sampled mid-run.
- len > DEPTH: clamped to DEPTH when latched.
- abort=1 in any non-IDLE state: next state IDLE, idx ← 0, no done pulse.
  - A pending out_valid drops on the next cycle.
  - abort has priority over out_ready in the same cycle.
  - abort in IDLE has no effect; if abort and start are both high in IDLE, start wins.
- op_reg and res_reg keep their last values in IDLE (no clear), so sp_operand is glitch-free.
- rst mid-run: the run is lost, no done pulse; a new start is required afterwards.

Test Plan:
- Common setup: buffer model with 1-cycle read latency; softplus stub sp_result = sp_operand + 16'h0001.
- Reset: assert rst mid-cycle → all outputs 0 immediately, state IDLE, busy=0.
- Single element: buffer[0]=16'h0100, len=1, start at edge k, out_ready=1 → rd_en in k+1, out_valid in k+4 with out_data=16'h0101 and out_idx=0, done in k+5 only.
- Four elements {0x0000, 0x7FFF, 0xFF00, 0x0080}, out_ready=1 → results {0x0001, 0x8000, 0xFF01, 0x0081} with idx 0..3, spaced 4 cycles apart; done in k+17.
- Backpressure: len=2, out_ready=0 for 5 cycles on element 0 → out_valid, out_data and out_idx stable for 5 cycles; no rd_en for element 1 until the handshake; total run extended by 5 cycles.
- len=0 → done in k+1, no rd_en, no out_valid; len=100 with DEPTH=64 → exactly 64 results, last out_idx=63.
- abort during OUT of element 2 of 4 → IDLE next cycle, no done; start asserted during the run is ignored; a new start then runs from idx 0.
